ob: RTL and testbench

Output-port arbiter and multiplexer for one switch output: the responder side of the input-buffer request/ack handshake. It collects the per-port request bits from the four input buffers (`ib`) and grants one input at a time, round-robin. It holds the grant for a whole packet (head through tail) and forwards the granted input's flits to the output link through a registered mux. One instance sits per output port, between the four `ib` instances and the next-hop `ib`.

---
 rtl/ob.sv | 91 +++++++++
 tb/tb_ob.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ob.sv
// Output-port arbiter/mux: grants one of four input buffers round-robin,
// holds the grant from head to tail and forwards flits through a registered mux.
module ob #(
  parameter int PORT = 0,
  parameter int NIN  = 4,
  parameter int PKTW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PKTW:0] pkti0,
  input  logic [PKTW:0] pkti1,
  input  logic [PKTW:0] pkti2,
  input  logic [PKTW:0] pkti3,
  input  logic [3:0]    req,
  input  logic          full,
  output logic [3:0]    ack,
  output logic [PKTW:0] pkto,
  output logic          busy
);

  if (NIN != 4 || PORT < 0 || PORT > 3) begin : g_param_check
    $error("ob: only NIN=4 and PORT in 0..3 are supported");
  end

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  // Handshake: the granted input pops one flit on every cycle its ack bit is
  // high; ack is combinational so a full downstream suppresses the pop at once.
  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    gnt;
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic [PKTW:0] sel;
  logic          accept;
  logic          is_tail;

  always_comb begin
    sel = pkti0;
    case (gnt)
      2'd0: sel = pkti0;
      2'd1: sel = pkti1;
      2'd2: sel = pkti2;
      2'd3: sel = pkti3;
      default: sel = pkti0;
    endcase
  end

  // Scan from the highest offset down so the nearest set bit after ptr wins.
  always_comb begin
    pick = ptr;
    idx  = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) pick = idx;
    end
  end

  assign accept  = (state == XFER) && !full;
  assign is_tail = (sel[PKTW:PKTW-1] == 2'b11);
  assign ack     = (!rst && accept) ? (4'b0001 << gnt) : 4'b0000;
  assign busy    = (state == XFER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      gnt   <= 2'd0;
      pkto  <= '0;
    end else begin
      pkto <= accept ? sel : '0;
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            gnt   <= pick;
            state <= XFER;
          end
        end
        XFER: begin
          // The just-served input drops to lowest priority.
          if (accept && is_tail) begin
            state <= IDLE;
            ptr   <= gnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ob.sv
// Bench for ob: arbitration vector table plus scenario sequences checked
// against a cycle model and an expected-output queue.
module tb_ob;

  logic       clk;
  logic       rst;
  logic [9:0] pkti0, pkti1, pkti2, pkti3;
  logic [3:0] req;
  logic       full;
  logic [3:0] ack;
  logic [9:0] pkto;
  logic       busy;

  ob #(.PORT(1), .NIN(4), .PKTW(9)) dut (
    .clk(clk), .rst(rst),
    .pkti0(pkti0), .pkti1(pkti1), .pkti2(pkti2), .pkti3(pkti3),
    .req(req), .full(full), .ack(ack), .pkto(pkto), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] in_q[4][$];
  logic [9:0] exp_q[$];
  logic [9:0] exp_out[$];
  logic [9:0] out_log[$];
  logic [1:0] gnt_log[$];

  logic       m_xfer;
  logic [1:0] m_gnt;
  logic [1:0] m_ptr;

  typedef struct {
    int         prev;
    logic [3:0] rq;
    logic [3:0] exp_ack;
  } rr_vec_t;

  rr_vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] head(input int i);
    return (in_q[i].size() > 0) ? in_q[i][0] : 10'b0;
  endfunction

  // driver: one clock cycle, with model-based checks of ack/busy/pkto
  task automatic cyc();
    logic [9:0] f;
    logic [9:0] e;
    logic [3:0] eack;
    logic [1:0] k;
    logic       found;
    pkti0 = head(0);
    pkti1 = head(1);
    pkti2 = head(2);
    pkti3 = head(3);
    #1;
    eack = (!rst && m_xfer && !full) ? (4'b0001 << m_gnt) : 4'b0000;
    check("ack", 32'(ack), 32'(eack));
    check("busy", 32'(busy), 32'(m_xfer));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pkto", 32'(pkto), 32'(e));
    end
    if (pkto != 10'b0) out_log.push_back(pkto);
    if (rst) begin
      m_xfer = 1'b0;
      m_ptr  = 2'd0;
      m_gnt  = 2'd0;
      exp_q.push_back(10'b0);
    end else if (m_xfer) begin
      if (!full) begin
        f = head(int'(m_gnt));
        exp_q.push_back(f);
        if (in_q[m_gnt].size() > 0) void'(in_q[m_gnt].pop_front());
        if (f[9:8] == 2'b11) begin
          m_xfer = 1'b0;
          m_ptr  = m_gnt + 2'd1;
        end
      end else begin
        exp_q.push_back(10'b0);
      end
    end else begin
      exp_q.push_back(10'b0);
      found = 1'b0;
      for (int j = 0; j < 4; j++) begin
        k = m_ptr + 2'(j);
        if (!found && req[k]) begin
          found  = 1'b1;
          m_gnt  = k;
          m_xfer = 1'b1;
          gnt_log.push_back(k);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    full = 1'b0;
    for (int i = 0; i < 4; i++) in_q[i].delete();
    cyc();
    rst = 1'b0;
    gnt_log.delete();
    out_log.delete();
    exp_out.delete();
  endtask

  task automatic push_pkt(input int i);
    logic [9:0] f[4];
    f[0] = {2'b10, 8'($urandom_range(0, 255))};
    f[1] = {2'b01, 8'($urandom_range(0, 255))};
    f[2] = {2'b01, 8'($urandom_range(0, 255))};
    f[3] = {2'b11, 8'($urandom_range(0, 255))};
    for (int j = 0; j < 4; j++) begin
      in_q[i].push_back(f[j]);
      exp_out.push_back(f[j]);
    end
  endtask

  task automatic run_until(input string name, input int ngnt, input int limit);
    logic done;
    done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      cyc();
      if (gnt_log.size() >= ngnt && !m_xfer) done = 1'b1;
    end
    check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic check_grants(input string name, input int exp_g[$]);
    check({name, "_ngrant"}, 32'(gnt_log.size()), 32'(exp_g.size()));
    for (int j = 0; j < exp_g.size() && j < gnt_log.size(); j++)
      check({name, "_grant"}, 32'(gnt_log[j]), 32'(exp_g[j]));
  endtask

  // scoreboard: forwarded flits in order against what the inputs supplied
  task automatic check_out(input string name);
    check({name, "_nflit"}, 32'(out_log.size()), 32'(exp_out.size()));
    for (int j = 0; j < exp_out.size() && j < out_log.size(); j++)
      check({name, "_flit"}, 32'(out_log[j]), 32'(exp_out[j]));
  endtask

  initial begin
    m_xfer = 1'b0; m_gnt = 2'd0; m_ptr = 2'd0;
    rst = 1'b1; req = 4'b1111; full = 1'b0;
    pkti0 = '0; pkti1 = '0; pkti2 = '0; pkti3 = '0;
    @(posedge clk);
    #1;

    tbl[0] = '{4, 4'b1111, 4'b0001};
    tbl[1] = '{4, 4'b0100, 4'b0100};
    tbl[2] = '{4, 4'b1010, 4'b0010};
    tbl[3] = '{0, 4'b1111, 4'b0010};
    tbl[4] = '{0, 4'b0001, 4'b0001};
    tbl[5] = '{1, 4'b0011, 4'b0001};
    tbl[6] = '{2, 4'b0111, 4'b0001};
    tbl[7] = '{3, 4'b1001, 4'b0001};
    tbl[8] = '{3, 4'b1000, 4'b1000};
    tbl[9] = '{1, 4'b1110, 4'b0100};

    // Reset with all requests pending
    rst = 1'b1; req = 4'b1111;
    cyc();
    rst = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkto", 32'(pkto), 32'd0);
    cyc();
    check("first_grant", 32'(ack), 32'(4'b0001));

    // Single packet from input 0
    do_reset();
    in_q[0] = '{10'b10_1001_0001, 10'b01_1001_0000, 10'b01_1001_0001, 10'b11_1001_0010};
    exp_out = '{10'b10_1001_0001, 10'b01_1001_0000, 10'b01_1001_0001, 10'b11_1001_0010};
    req = 4'b0001;
    run_until("single", 1, 20);
    check("single_ack_drop", 32'(ack), 32'd0);
    req = 4'b0000;
    cyc();
    check_out("single");

    // Round-robin with req = 1011 held
    do_reset();
    push_pkt(0); push_pkt(1); push_pkt(3); push_pkt(0);
    req = 4'b1011;
    run_until("rr", 4, 60);
    req = 4'b0000;
    cyc();
    check_grants("rr", '{0, 1, 3, 0});
    check_out("rr");

    // Stall for 3 cycles after the head
    do_reset();
    push_pkt(2);
    req = 4'b0100;
    cyc();
    cyc();
    full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cyc();
      check("stall_pkto", 32'(pkto), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    full = 1'b0;
    run_until("stall", 1, 20);
    cyc();
    check_out("stall");

    // Request change mid-packet
    do_reset();
    push_pkt(0); push_pkt(2);
    req = 4'b0001;
    cyc();
    cyc();
    req = 4'b0100;
    run_until("reqchg", 2, 30);
    req = 4'b0000;
    cyc();
    check_grants("reqchg", '{0, 2});
    check_out("reqchg");

    // Reset mid-packet after ptr has moved to 3
    do_reset();
    push_pkt(2);
    req = 4'b0100;
    run_until("pre_abort", 1, 20);
    push_pkt(1);
    req = 4'b0010;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 4'b1010;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pkto", 32'(pkto), 32'd0);
    for (int i = 0; i < 4; i++) in_q[i].delete();
    cyc();
    check("abort_ptr", 32'(ack), 32'(4'b0010));

    // Arbitration table
    for (int t = 0; t < 10; t++) begin
      do_reset();
      if (tbl[t].prev < 4) begin
        in_q[tbl[t].prev].push_back(10'b10_0000_0001);
        in_q[tbl[t].prev].push_back(10'b11_0000_0010);
        req = 4'b0001 << tbl[t].prev;
        run_until("tbl_pre", 1, 20);
      end
      req = tbl[t].rq;
      cyc();
      check($sformatf("tbl%0d_ack", t), 32'(ack), 32'(tbl[t].exp_ack));
    end

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
